// File: rtl/skein_best_result_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | skein_best_result_ctrl                                                   |
// | Controller for the primary/secondary register datapath that keeps the    |
// | best Skein candidate seen so far. The optional macro                     |
// | SKEIN_BEST_TIE_NEWER_EN lets an equal distance replace the stored best.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module skein_best_result_ctrl #(
  parameter int DIST_W  = 10,
  parameter int CMP_LAT = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               cand_valid_i,
  output logic               cand_ready_o,
  input  logic [63:0]        cand_nonce_i,
  input  logic [DIST_W-1:0]  cand_dist_i,
  output logic               primary_load_o,
  output logic               secondary_load_o,
  output logic               primary_register_select_o,
  output logic               comparator_select_o,
  output logic               done_o,
  output logic               improved_o,
  output logic               best_valid_o,
  output logic [DIST_W-1:0]  best_dist_o,
  output logic [63:0]        best_nonce_o,
  output logic [COUNT_W-1:0] improve_count_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPARE = 2'd2,
    S_WRITE   = 2'd3
  } state_e;

  localparam logic [3:0] C_LAT_INIT = 4'(CMP_LAT - 1);

  state_e               state_q, state_d;
  logic [3:0]           lat_q, lat_d;
  logic [63:0]          cand_nonce_q;
  logic [DIST_W-1:0]    cand_dist_q;
  logic                 win_q;
  logic                 best_valid_q;
  logic [DIST_W-1:0]    best_dist_q;
  logic [63:0]          best_nonce_q;
  logic [COUNT_W-1:0]   count_q;

  logic w_better;
  logic w_win_eval;
  logic w_accept;
  logic w_eval;
  logic w_commit;

`ifdef SKEIN_BEST_TIE_NEWER_EN
  assign w_better = (cand_dist_q <= best_dist_q);
`else
  assign w_better = (cand_dist_q < best_dist_q);
`endif

  // A clear landing on the evaluation cycle already counts as "no best held".
  assign w_win_eval = !(best_valid_q && !clear_i) || w_better;
  assign w_accept   = (state_q == S_IDLE) && cand_valid_i;
  assign w_eval     = (state_q == S_COMPARE) && (lat_q == 4'd0);
  assign w_commit   = (state_q == S_WRITE) && win_q && !clear_i;

  always_comb begin
    state_d                   = state_q;
    lat_d                     = lat_q;
    cand_ready_o              = 1'b0;
    primary_load_o            = 1'b0;
    secondary_load_o          = 1'b0;
    primary_register_select_o = 1'b0;
    comparator_select_o       = 1'b0;
    done_o                    = 1'b0;
    improved_o                = 1'b0;
    case (state_q)
      S_IDLE: begin
        cand_ready_o = 1'b1;
        if (cand_valid_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        primary_load_o            = 1'b1;
        primary_register_select_o = 1'b1;
        lat_d                     = C_LAT_INIT;
        state_d                   = S_COMPARE;
      end
      S_COMPARE: begin
        if (lat_q == 4'd0) state_d = S_WRITE;
        else               lat_d   = lat_q - 4'd1;
      end
      S_WRITE: begin
        // A losing candidate leaves the demux on the secondary, so the reload holds.
        secondary_load_o    = 1'b1;
        comparator_select_o = win_q;
        done_o              = 1'b1;
        improved_o          = win_q && !clear_i;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      cand_nonce_q <= '0;
      cand_dist_q  <= '0;
      win_q        <= 1'b0;
      best_valid_q <= 1'b0;
      best_dist_q  <= '0;
      best_nonce_q <= '0;
      count_q      <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (w_accept) begin
        cand_nonce_q <= cand_nonce_i;
        cand_dist_q  <= cand_dist_i;
      end
      if (w_eval) win_q <= w_win_eval;
      if (clear_i) begin
        best_valid_q <= 1'b0;
        count_q      <= '0;
      end else if (w_commit) begin
        best_valid_q <= 1'b1;
        best_dist_q  <= cand_dist_q;
        best_nonce_q <= cand_nonce_q;
        if (count_q != {COUNT_W{1'b1}}) count_q <= count_q + 1'b1;
      end
    end
  end

  assign best_valid_o    = best_valid_q;
  assign best_dist_o     = best_dist_q;
  assign best_nonce_o    = best_nonce_q;
  assign improve_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_skein_best_result_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_skein_best_result_ctrl                                                |
// | Directed self-checking bench for skein_best_result_ctrl (CMP_LAT=2).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_skein_best_result_ctrl;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          cand_valid_i = 1'b0;
  logic [63:0]   cand_nonce_i = '0;
  logic [DW-1:0] cand_dist_i = '0;

  logic          cand_ready_o, primary_load_o, secondary_load_o;
  logic          primary_register_select_o, comparator_select_o;
  logic          done_o, improved_o, best_valid_o;
  logic [DW-1:0] best_dist_o;
  logic [63:0]   best_nonce_o;
  logic [15:0]   improve_count_o;

  logic          s_ready, s_pl, s_sl, s_prs, s_cs, s_done, s_imp, s_bv;
  logic [DW-1:0] s_bd;
  logic [63:0]   s_bn;
  logic [1:0]    s_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int excl_viol = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  skein_best_result_ctrl #(.DIST_W(DW), .CMP_LAT(2), .COUNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .cand_valid_i(cand_valid_i), .cand_ready_o(cand_ready_o),
    .cand_nonce_i(cand_nonce_i), .cand_dist_i(cand_dist_i),
    .primary_load_o(primary_load_o), .secondary_load_o(secondary_load_o),
    .primary_register_select_o(primary_register_select_o),
    .comparator_select_o(comparator_select_o),
    .done_o(done_o), .improved_o(improved_o), .best_valid_o(best_valid_o),
    .best_dist_o(best_dist_o), .best_nonce_o(best_nonce_o),
    .improve_count_o(improve_count_o)
  );

  skein_best_result_ctrl #(.DIST_W(DW), .CMP_LAT(2), .COUNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .cand_valid_i(cand_valid_i), .cand_ready_o(s_ready),
    .cand_nonce_i(cand_nonce_i), .cand_dist_i(cand_dist_i),
    .primary_load_o(s_pl), .secondary_load_o(s_sl),
    .primary_register_select_o(s_prs), .comparator_select_o(s_cs),
    .done_o(s_done), .improved_o(s_imp), .best_valid_o(s_bv),
    .best_dist_o(s_bd), .best_nonce_o(s_bn), .improve_count_o(s_cnt)
  );

  always @(negedge clk) begin
    if (primary_register_select_o && comparator_select_o) excl_viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ready"}, 64'(cand_ready_o), 64'd1);
    chk({pfx, "_pload"}, 64'(primary_load_o), 64'd0);
    chk({pfx, "_sload"}, 64'(secondary_load_o), 64'd0);
    chk({pfx, "_psel"},  64'(primary_register_select_o), 64'd0);
    chk({pfx, "_csel"},  64'(comparator_select_o), 64'd0);
    chk({pfx, "_done"},  64'(done_o), 64'd0);
    chk({pfx, "_impr"},  64'(improved_o), 64'd0);
    chk({pfx, "_bvalid"}, 64'(best_valid_o), 64'd0);
    chk({pfx, "_bdist"}, 64'(best_dist_o), 64'd0);
    chk({pfx, "_bnonce"}, best_nonce_o, 64'd0);
    chk({pfx, "_count"}, 64'(improve_count_o), 64'd0);
  endtask

  // Entered on a falling edge with the DUT idle; returns on a falling edge, idle again.
  task automatic do_cand(input logic [63:0] n, input logic [DW-1:0] d, input int clr_at,
                         output int pl_lat, output logic prs, output int done_lat,
                         output logic imp, output logic csel, output logic sl);
    pl_lat = -1; done_lat = -1; prs = 1'b0; imp = 1'b0; csel = 1'b0; sl = 1'b0;
    cand_valid_i = 1'b1; cand_nonce_i = n; cand_dist_i = d;
    for (int k = 1; k <= 30 && done_lat < 0; k++) begin
      @(negedge clk);
      cand_valid_i = 1'b0;
      clear_i = (k == clr_at);
      #1;
      if (primary_load_o) begin pl_lat = k; prs = primary_register_select_o; end
      if (done_o) begin
        done_lat = k; imp = improved_o; csel = comparator_select_o; sl = secondary_load_o;
      end
    end
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  initial begin
    int   pl_lat, done_lat, cyc, nacc, low_run;
    int   acc [3];
    logic prs, imp, csel, sl;

    // Reset
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("rst");

    // First candidate always wins
    do_cand(64'h1, 10'd500, 0, pl_lat, prs, done_lat, imp, csel, sl);
    chk("c1_pload_lat", 64'(pl_lat), 64'd1);
    chk("c1_psel_load", 64'(prs), 64'd1);
    chk("c1_done_lat", 64'(done_lat), 64'd4);
    chk("c1_impr", 64'(imp), 64'd1);
    chk("c1_csel", 64'(csel), 64'd1);
    chk("c1_sload", 64'(sl), 64'd1);
    chk("c1_bdist", 64'(best_dist_o), 64'd500);
    chk("c1_bnonce", best_nonce_o, 64'h1);
    chk("c1_bvalid", 64'(best_valid_o), 64'd1);
    chk("c1_count", 64'(improve_count_o), 64'd1);

    // Worse candidate: secondary holds
    do_cand(64'h2, 10'd600, 0, pl_lat, prs, done_lat, imp, csel, sl);
    chk("c2_done_lat", 64'(done_lat), 64'd4);
    chk("c2_impr", 64'(imp), 64'd0);
    chk("c2_csel", 64'(csel), 64'd0);
    chk("c2_sload", 64'(sl), 64'd1);
    chk("c2_bdist", 64'(best_dist_o), 64'd500);
    chk("c2_bnonce", best_nonce_o, 64'h1);
    chk("c2_count", 64'(improve_count_o), 64'd1);

    // Better candidate
    do_cand(64'h3, 10'd420, 0, pl_lat, prs, done_lat, imp, csel, sl);
    chk("c3_impr", 64'(imp), 64'd1);
    chk("c3_bdist", 64'(best_dist_o), 64'd420);
    chk("c3_bnonce", best_nonce_o, 64'h3);
    chk("c3_count", 64'(improve_count_o), 64'd2);

    // Tie
    do_cand(64'h4, 10'd420, 0, pl_lat, prs, done_lat, imp, csel, sl);
`ifdef SKEIN_BEST_TIE_NEWER_EN
    chk("tie_impr", 64'(imp), 64'd1);
    chk("tie_bnonce", best_nonce_o, 64'h4);
    chk("tie_count", 64'(improve_count_o), 64'd3);
    exp_cnt = 3;
`else
    chk("tie_impr", 64'(imp), 64'd0);
    chk("tie_bnonce", best_nonce_o, 64'h3);
    chk("tie_count", 64'(improve_count_o), 64'd2);
    exp_cnt = 2;
`endif

    // Back-to-back: valid held high across three (losing) candidates
    nacc = 0; low_run = 0; cyc = 0;
    cand_valid_i = 1'b1; cand_nonce_i = 64'h50; cand_dist_i = 10'd800;
    #1;
    while (nacc < 3 && cyc < 40) begin
      if (cand_ready_o) begin
        acc[nacc] = cyc;
        if (nacc == 1) chk("b2b_ready_low_run", 64'(low_run), 64'd4);
        nacc++;
      end else if (nacc == 1) begin
        low_run++;
      end
      @(negedge clk);
      cyc++;
      cand_nonce_i = cand_nonce_i + 64'h1;
      cand_dist_i  = cand_dist_i + 10'd10;
      if (nacc == 3) cand_valid_i = 1'b0;
      #1;
    end
    chk("b2b_accepts", 64'(nacc), 64'd3);
    chk("b2b_gap1", 64'(acc[1] - acc[0]), 64'd5);
    chk("b2b_gap2", 64'(acc[2] - acc[1]), 64'd5);
    cyc = 0;
    while (!cand_ready_o && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    chk("b2b_drain_ready", 64'(cand_ready_o), 64'd1);
    @(negedge clk);
    chk("b2b_bdist", 64'(best_dist_o), 64'd420);
    chk("b2b_count", 64'(improve_count_o), 64'(exp_cnt));

    // Clear in the WRITE cycle of a winner
    do_cand(64'h10, 10'd10, 4, pl_lat, prs, done_lat, imp, csel, sl);
    chk("clrw_done_lat", 64'(done_lat), 64'd4);
    chk("clrw_impr", 64'(imp), 64'd0);
    chk("clrw_csel", 64'(csel), 64'd1);
    chk("clrw_bvalid", 64'(best_valid_o), 64'd0);
    chk("clrw_count", 64'(improve_count_o), 64'd0);

    // Establish a best, then clear during COMPARE: a poor candidate still wins
    do_cand(64'h6, 10'd100, 0, pl_lat, prs, done_lat, imp, csel, sl);
    chk("pre_clrc_bdist", 64'(best_dist_o), 64'd100);
    do_cand(64'h7, 10'd900, 2, pl_lat, prs, done_lat, imp, csel, sl);
    chk("clrc_impr", 64'(imp), 64'd1);
    chk("clrc_bdist", 64'(best_dist_o), 64'd900);
    chk("clrc_bnonce", best_nonce_o, 64'h7);
    chk("clrc_count", 64'(improve_count_o), 64'd1);

    // Saturation with COUNT_W=2
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++)
      do_cand(64'(i + 32), 10'(400 - 100 * i), 0, pl_lat, prs, done_lat, imp, csel, sl);
    chk("sat_count_w2", 64'(s_cnt), 64'd3);
    chk("sat_count_w16", 64'(improve_count_o), 64'd4);
    chk("sat_bdist", 64'(best_dist_o), 64'd100);

    // Reset asserted in COMPARE
    cand_valid_i = 1'b1; cand_nonce_i = 64'h99; cand_dist_i = 10'd5;
    @(negedge clk);
    cand_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (done_o) cyc++;
    end
    chk("midrst_no_done", 64'(cyc), 64'd0);

    chk("select_exclusive", 64'(excl_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/skein_best_result_ctrl.md
Name: skein_best_result_ctrl

Overview:
- Sequences the primary/secondary register passthrough datapath that tracks the best Skein candidate found so far.
- Accepts a candidate (nonce plus Hamming distance) over a valid/ready handshake and loads the nonce into the primary register.
- Waits a fixed comparator latency, then drives the demux selects so that the secondary (best) register either captures the primary or recirculates itself.
- Mirrors the best distance, best nonce and improvement count for host readout.

Parameters:
- DIST_W, 10, width of the Hamming distance field (max distance 1023).
- CMP_LAT, 2, comparator latency in cycles; legal range 1..15.
- COUNT_W, 16, width of the improvement counter.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  one-cycle pulse that forgets the best result.
- cand_valid_i  in  1  candidate valid.
- cand_ready_o  out  1  controller can accept a candidate.
- cand_nonce_i  in  64  candidate nonce.
- cand_dist_i  in  DIST_W  candidate Hamming distance.
- primary_load_o  out  1  primary register load enable.
- secondary_load_o  out  1  secondary register load enable (loads the demux output).
- primary_register_select_o  out  1  demux select: pass the primary register.
- comparator_select_o  out  1  demux select: comparator-won, pass the primary register.
- done_o  out  1  one-cycle pulse when a candidate completes.
- improved_o  out  1  valid with done_o; 1 if the candidate became the new best.
- best_valid_o  out  1  a best result is held.
- best_dist_o  out  DIST_W  best distance.
- best_nonce_o  out  64  best nonce (mirror of the secondary register).
- improve_count_o  out  COUNT_W  number of improvements; saturates at all-ones.

Behaviour:
- Reset values:
  - State is IDLE.
  - cand_ready_o=1; all other outputs 0, including best_dist_o, best_nonce_o and improve_count_o.
- FSM states: IDLE, LOAD, COMPARE, WRITE.
- IDLE:
  - cand_ready_o=1.
  - On cand_valid_i&&cand_ready_o: latch nonce and distance internally, go to LOAD.
- LOAD (1 cycle):
  - cand_ready_o=0, primary_load_o=1, primary_register_select_o=1.
  - Go to COMPARE and load the latency counter with CMP_LAT-1.
- COMPARE (CMP_LAT cycles):
  - Counter decrements each cycle.
  - At 0, evaluate win = !best_valid || (cand_dist < best_dist), register it, go to WRITE.
- WRITE (1 cycle):
  - secondary_load_o=1, comparator_select_o=win, primary_register_select_o=0.
  - done_o=1, improved_o=win.
  - If win: best_dist<=cand_dist, best_nonce<=cand_nonce, best_valid<=1, improve_count increments with saturation.
  - Go to IDLE.
- Timing:
  - Accept in cycle T; done_o in cycle T+2+CMP_LAT.
  - cand_ready_o returns high in cycle T+3+CMP_LAT; throughput is one candidate per 3+CMP_LAT cycles.
  - With win=0 the demux passes the secondary register, so the secondary reload is a hold.
- Select exclusivity: primary_register_select_o and comparator_select_o are never both 1. Both are 0 outside LOAD/WRITE.
- Arithmetic: the distance compare is unsigned and full DIST_W wide.
- clear_i, any state:
  - Next cycle best_valid_o=0 and improve_count_o=0.
  - best_dist_o and best_nonce_o are retained but meaningless.
  - Does not abort an in-flight candidate.
- clear_i in the WRITE cycle: clear has priority.
  - Candidate is discarded: best_valid_o=0, count=0, improved_o=0.
  - done_o still pulses; secondary_load_o and comparator_select_o are still driven per win.
- clear_i during COMPARE before evaluation: the candidate wins, since best_valid=0.
- rst_i mid-operation: returns to IDLE with reset values; the in-flight candidate is lost and no done_o is issued.
- cand_* inputs are ignored while cand_ready_o=0.

Optional Feature:
- Macro: SKEIN_BEST_TIE_NEWER_EN.
- Defined: win = !best_valid || (cand_dist <= best_dist). An equal distance replaces the best and increments the count.
- Undefined: strict <; on a tie the older best is kept and improved_o=0.

Test Plan:
- Reset, then accept nonce=0x1, dist=500 at cycle T -> primary_load_o at T+1; done_o and improved_o=1 at T+4 (CMP_LAT=2); best_dist_o=500, best_nonce_o=0x1, improve_count_o=1.
- Follow with dist=600 -> improved_o=0, comparator_select_o=0 during WRITE, best unchanged, count=1. Then dist=420 -> best_dist_o=420, count=2.
- Tie: dist=420 again -> without the macro improved_o=0, count=2; with SKEIN_BEST_TIE_NEWER_EN improved_o=1, new nonce taken, count=3.
- Back-to-back cand_valid_i held high for 3 candidates -> accepts spaced exactly 5 cycles apart; cand_ready_o low for 4 cycles after each accept.
- clear_i in a WRITE cycle with a winning dist=10 -> best_valid_o=0, count=0, improved_o=0, done_o=1. clear_i during COMPARE with dist=900 -> that candidate becomes best, count=1.
- COUNT_W=2 override, 4 improving candidates -> improve_count_o saturates at 3. rst_i asserted in COMPARE -> IDLE next cycle, no done_o, all outputs at reset values.
